wr_burst_feeder: RTL and testbench

- Upstream stage of the AXI write master in the DDR2 controller write path.
- Accepts a valid/ready data stream and buffers it in an internal first-word-fall-through FIFO.
- When a full burst is buffered, or a flush is requested, it pulses the master's write trigger with a stable address and length, then supplies data beats on the master's data-enable strobe.
- Maintains a linearly incrementing, wrapping write address inside a fixed DDR region.

---
 rtl/wr_burst_feeder.sv | 169 ++++++++++++++++
 tb/tb_wr_burst_feeder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_burst_feeder.sv
// wr_burst_feeder: buffers a valid/ready stream in a FWFT FIFO and feeds it to
// the DDR2 AXI write master in bursts, tracking a wrapping write address inside
// a fixed DDR region.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a full burst (or a flush with data) and an idle master
// TRIG   | wr_trig asserted for one cycle, wr_len/wr_addr already latched
// WAIT   | master is moving the burst; wait for wr_done, then advance offset
module wr_burst_feeder #(
  parameter int                    ADDR_WIDTH  = 26,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    WBURST_LEN  = 8,
  parameter int                    FIFO_DEPTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE   = '0,
  parameter int                    REGION_SIZE = 2**20,
  parameter int                    ADDR_STEP   = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            init_end,
  input  logic                            src_valid,
  input  logic [DATA_WIDTH-1:0]           src_data,
  output logic                            src_ready,
  input  logic                            flush,
  input  logic                            addr_rst,
  output logic                            wr_trig,
  output logic [7:0]                      wr_len,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            wr_data_en,
  input  logic                            wr_ready,
  input  logic                            wr_done,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]      DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]      BURST_LVL = LVL_W'(WBURST_LEN);
  localparam logic [ADDR_WIDTH:0]   REGION_W  = (ADDR_WIDTH+1)'(REGION_SIZE);
  localparam logic [ADDR_WIDTH:0]   STEP_W    = (ADDR_WIDTH+1)'(ADDR_STEP);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TRIG = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  flush_pending;
  logic                  addr_rst_pending;

  logic                  push;
  logic                  pop;
  logic                  burst_full;
  logic                  trig_cond;
  logic [ADDR_WIDTH-1:0] eff_offset;
  logic [ADDR_WIDTH:0]   burst_amt;
  logic [ADDR_WIDTH:0]   offset_sum;
  logic [ADDR_WIDTH:0]   offset_next;

  assign src_ready  = (level != DEPTH_LVL);
  assign push       = src_valid & src_ready;
  assign pop        = wr_data_en & (level != '0);
  assign wr_data    = mem[rd_ptr];
  assign fifo_level = level;
  assign wr_trig    = (state == S_TRIG);

  // A full burst always wins; a short burst only drains a pending flush.
  assign burst_full = (level >= BURST_LVL);
  assign trig_cond  = (state == S_IDLE) & init_end & wr_ready &
                      (burst_full | (flush_pending & (level != '0)));

  // addr_rst in the same IDLE cycle as a trigger must already apply to that burst.
  assign eff_offset  = addr_rst ? '0 : offset;
  assign burst_amt   = (ADDR_WIDTH+1)'(wr_len) * STEP_W;
  assign offset_sum  = {1'b0, offset} + burst_amt;
  assign offset_next = (offset_sum >= REGION_W) ? (offset_sum - REGION_W) : offset_sum;

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= src_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves level unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky flag for a beat requested while nothing was buffered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (wr_data_en && (level == '0)) begin
      underflow <= 1'b1;
    end
  end

  // Flush request is remembered until the FIFO has been seen empty in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_pending <= 1'b0;
    end else if (flush) begin
      flush_pending <= 1'b1;
    end else if ((state == S_IDLE) && (level == '0)) begin
      flush_pending <= 1'b0;
    end
  end

  // Burst sequencing, burst descriptor latching and region offset tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      wr_len           <= '0;
      wr_addr          <= ADDR_BASE;
      offset           <= '0;
      addr_rst_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (addr_rst) offset <= '0;
          if (trig_cond) begin
            state   <= S_TRIG;
            wr_len  <= burst_full ? 8'(WBURST_LEN) : 8'(level);
            wr_addr <= ADDR_BASE + eff_offset;
          end
        end
        S_TRIG: begin
          if (addr_rst) addr_rst_pending <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wr_done) begin
            state            <= S_IDLE;
            addr_rst_pending <= 1'b0;
            if (addr_rst || addr_rst_pending) begin
              offset <= '0;
            end else begin
              offset <= offset_next[ADDR_WIDTH-1:0];
            end
          end else if (addr_rst) begin
            addr_rst_pending <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wr_burst_feeder.sv
// Bench for wr_burst_feeder: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a queue-based reference model.
module tb_wr_burst_feeder;

  localparam int AW     = 26;
  localparam int DW     = 32;
  localparam int BL     = 8;
  localparam int DEPTH  = 64;
  localparam int REGION = 24;
  localparam int STEP   = 1;
  localparam int LVL_W  = 7;
  localparam logic [AW-1:0] BASE = 26'h200;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             init_end;
  logic             src_valid;
  logic [DW-1:0]    src_data;
  logic             src_ready;
  logic             flush;
  logic             addr_rst;
  logic             wr_trig;
  logic [7:0]       wr_len;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             wr_data_en;
  logic             wr_ready;
  logic             wr_done;
  logic [LVL_W-1:0] fifo_level;
  logic             underflow;

  always #5 clk = ~clk;

  wr_burst_feeder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WBURST_LEN (BL),
    .FIFO_DEPTH (DEPTH),
    .ADDR_BASE  (BASE),
    .REGION_SIZE(REGION),
    .ADDR_STEP  (STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_end  (init_end),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .flush     (flush),
    .addr_rst  (addr_rst),
    .wr_trig   (wr_trig),
    .wr_len    (wr_len),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_data_en(wr_data_en),
    .wr_ready  (wr_ready),
    .wr_done   (wr_done),
    .fifo_level(fifo_level),
    .underflow (underflow)
  );

  int n_tests;
  int n_fail;

  // reference model state
  logic [DW-1:0] q[$];
  bit            m_trig, m_wait, m_fp, m_arp, m_uf;
  int            m_off, m_len;
  logic [AW-1:0] m_addr;

  // master / source / scenario state
  bit            mst_active;
  int            mst_beats;
  bit            hold_ready;
  bit            rand_mode;
  int            src_left;
  logic [DW-1:0] next_word;
  int            dut_bursts;
  logic [AW-1:0] blog_addr[$];
  int            blog_len[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_trig = 0; m_wait = 0; m_fp = 0; m_arp = 0; m_uf = 0;
    m_off = 0; m_len = 0; m_addr = BASE;
    mst_active = 0; mst_beats = 0;
  endtask

  task automatic drive();
    src_valid  = (src_left > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
    src_data   = next_word;
    wr_data_en = mst_active && (mst_beats > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
    wr_done    = mst_active && (mst_beats == 0) && m_wait && (!rand_mode || $urandom_range(0, 2) != 0);
    wr_ready   = !hold_ready && (!mst_active || wr_done);
    flush      = rand_mode && ($urandom_range(0, 59) == 0);
    addr_rst   = rand_mode && ($urandom_range(0, 89) == 0);
  endtask

  // One clock: predict from the inputs of this cycle, advance, compare, re-drive.
  task automatic tick();
    int sz;
    bit idle, push, pop, cond, rst_now;
    sz      = q.size();
    rst_now = !rst_n;
    idle    = !m_trig && !m_wait;
    push    = src_valid && (sz != DEPTH);
    pop     = wr_data_en && (sz != 0);
    if (pop) chk("wr_data", wr_data, q[0]);
    cond = idle && init_end && wr_ready && (sz >= BL || (m_fp && sz != 0));
    @(posedge clk);
    #1;
    if (rst_now) begin
      model_reset();
    end else begin
      if (wr_data_en && sz == 0) m_uf = 1;
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(src_data);
        src_left--;
        next_word++;
      end
      if (flush) m_fp = 1;
      else if (idle && sz == 0) m_fp = 0;
      if (cond) begin
        m_len  = (sz >= BL) ? BL : sz;
        m_addr = BASE + AW'(addr_rst ? 0 : m_off);
      end
      if (idle) begin
        if (addr_rst) m_off = 0;
      end else if (m_wait && wr_done) begin
        m_off = (m_arp || addr_rst) ? 0 : (m_off + m_len * STEP) % REGION;
        m_arp = 0;
      end else if (addr_rst) begin
        m_arp = 1;
      end
      m_wait = m_trig || (m_wait && !wr_done);
      m_trig = cond;
      if (pop && mst_active) mst_beats--;
      if (wr_done) mst_active = 0;
      if (m_trig) begin
        mst_active = 1;
        mst_beats  = m_len;
      end
    end
    chk("wr_trig", wr_trig, m_trig);
    chk("wr_len", wr_len, m_len);
    chk("wr_addr", wr_addr, m_addr);
    chk("fifo_level", fifo_level, q.size());
    chk("src_ready", src_ready, q.size() != DEPTH);
    chk("underflow", underflow, m_uf);
    if (wr_trig === 1'b1) begin
      dut_bursts++;
      blog_addr.push_back(wr_addr);
      blog_len.push_back(int'(wr_len));
    end
    drive();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(src_left == 0 && q.size() == 0 && !m_trig && !m_wait && !mst_active) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_settle"}, n < budget, 1);
  endtask

  task automatic chk_burst(input string tag, input int idx, input logic [AW-1:0] ea, input int el);
    if (idx < blog_addr.size()) begin
      chk({tag, "_addr"}, blog_addr[idx], ea);
      chk({tag, "_len"}, blog_len[idx], el);
    end else begin
      chk({tag, "_missing"}, blog_addr.size(), idx + 1);
    end
  endtask

  initial begin
    int b0;
    int n;
    n_tests = 0; n_fail = 0; dut_bursts = 0;
    rst_n = 0; init_end = 0; hold_ready = 0; rand_mode = 0;
    src_left = 0; next_word = 32'h100;
    model_reset();
    drive();
    repeat (3) tick();
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", src_ready, 1);
    chk("rst_addr", wr_addr, BASE);
    chk("rst_len", wr_len, 0);
    chk("rst_trig", wr_trig, 0);
    chk("rst_uf", underflow, 0);
    rst_n = 1; init_end = 1;
    tick();

    // two full bursts, second one at +8
    addr_rst = 1; tick();
    b0 = dut_bursts; next_word = 32'h100; src_left = 8;
    wait_idle(200, "s2a");
    src_left = 8;
    wait_idle(200, "s2b");
    chk("s2_nburst", dut_bursts - b0, 2);
    chk_burst("s2_b0", b0, BASE, 8);
    chk_burst("s2_b1", b0 + 1, BASE + 8, 8);

    // short burst on flush; flush with empty FIFO issues nothing
    addr_rst = 1; tick();
    b0 = dut_bursts; src_left = 3;
    repeat (6) tick();
    chk("s3_no_early", dut_bursts - b0, 0);
    flush = 1; tick();
    wait_idle(200, "s3");
    chk("s3_nburst", dut_bursts - b0, 1);
    chk_burst("s3_b0", b0, BASE, 3);
    b0 = dut_bursts;
    flush = 1; tick();
    repeat (20) tick();
    chk("s3_empty_flush", dut_bursts - b0, 0);

    // backpressure: fill to 64, then drain with wrapping addresses
    addr_rst = 1; tick();
    b0 = dut_bursts; hold_ready = 1; src_left = 70;
    repeat (90) tick();
    chk("s4_full_level", fifo_level, 64);
    chk("s4_ready_low", src_ready, 0);
    chk("s4_no_burst", dut_bursts - b0, 0);
    hold_ready = 0; flush = 1; tick();
    wait_idle(2000, "s4");
    chk("s4_nburst", dut_bursts - b0, 9);
    for (int i = 0; i < 8; i++)
      chk_burst($sformatf("s4_b%0d", i), b0 + i, BASE + AW'((i * 8) % REGION), 8);
    chk_burst("s4_tail", b0 + 8, BASE + AW'(64 % REGION), 6);

    // addr_rst while the burst at +8 is in flight
    addr_rst = 1; tick();
    b0 = dut_bursts; src_left = 16; n = 0;
    while (!(dut_bursts == b0 + 2 && m_wait) && n < 300) begin
      tick();
      n++;
    end
    chk("s6_reach", n < 300, 1);
    addr_rst = 1; tick();
    src_left = 8;
    wait_idle(400, "s6");
    chk_burst("s6_b1", b0 + 1, BASE + 8, 8);
    chk_burst("s6_b2", b0 + 2, BASE, 8);

    // init_end low gates bursts but not data
    addr_rst = 1; tick();
    init_end = 0; b0 = dut_bursts; src_left = 12;
    repeat (40) tick();
    chk("s7_no_burst", dut_bursts - b0, 0);
    chk("s7_level", fifo_level, 12);
    init_end = 1; flush = 1; tick();
    wait_idle(300, "s7");
    chk_burst("s7_b0", b0, BASE, 8);
    chk_burst("s7_b1", b0 + 1, BASE + 8, 4);

    // randomized traffic
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      if (src_left == 0 && $urandom_range(0, 9) == 0) begin
        src_left  = $urandom_range(1, 20);
        next_word = $urandom();
      end
      if ($urandom_range(0, 199) == 0) hold_ready = !hold_ready;
      if ($urandom_range(0, 299) == 0) init_end = !init_end;
      tick();
    end
    rand_mode = 0; hold_ready = 0; init_end = 1; src_left = 0;
    tick();
    flush = 1; tick();
    wait_idle(2000, "s8");

    // underflow is sticky; reset mid-burst clears everything
    wr_data_en = 1; tick();
    chk("s9_uf_set", underflow, 1);
    repeat (5) tick();
    chk("s9_uf_hold", underflow, 1);
    src_left = 8; n = 0;
    while (!m_wait && n < 100) begin
      tick();
      n++;
    end
    chk("s9_reach", n < 100, 1);
    rst_n = 0; src_left = 0;
    tick();
    chk("s9_level", fifo_level, 0);
    chk("s9_trig", wr_trig, 0);
    chk("s9_uf_clr", underflow, 0);
    chk("s9_ready", src_ready, 1);
    rst_n = 1;
    b0 = dut_bursts;
    repeat (10) tick();
    chk("s9_idle", dut_bursts - b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
